// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// The datapath side (master) supplies stage information and memory
// handshakes; the controller side (slave) returns stall/flush controls.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_mispredict;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             if_stall;
  logic             id_stall;
  logic             ex_stall;
  logic             mem_stall;
  logic             id_flush;
  logic             ex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_mispredict, imem_ready, dmem_req, dmem_ready,
    input  if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush,
           halted, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_mispredict, imem_ready, dmem_req, dmem_ready,
    output if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush,
           halted, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes the whole pipeline on data-memory
// waits (halting after TIMEOUT wait cycles), flushes on branch mispredict,
// stalls one cycle on load-use, and inserts bubbles on fetch waits.
// Also keeps a saturating count of front-end stall cycles.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    HALT      = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic freeze;
  logic release_c;
  logic load_use;
  logic if_stall_c, id_stall_c, ex_stall_c, mem_stall_c;
  logic id_flush_c, ex_flush_c;

  // State and wait counter; reset drops straight back to RUN from anywhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic for the data-memory wait / timeout machine.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          state_d    = DMEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      DMEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d    = HALT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Load-use detection; x0 is hardwired zero so it never creates a hazard.
  always_comb begin
    load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));
  end

  // Prioritised stall/flush decode: freeze > mispredict > load-use > fetch wait.
  always_comb begin
    if_stall_c  = 1'b0;
    id_stall_c  = 1'b0;
    ex_stall_c  = 1'b0;
    mem_stall_c = 1'b0;
    id_flush_c  = 1'b0;
    ex_flush_c  = 1'b0;
    freeze      = ((state_q == RUN) && hz.dmem_req && !hz.dmem_ready) ||
                  ((state_q == DMEM_WAIT) && !hz.dmem_ready) ||
                  (state_q == HALT);
    release_c   = (state_q == DMEM_WAIT) && hz.dmem_ready;

    if (freeze) begin
      // Mispredicts are dropped here; the held EX instruction raises it again.
      if_stall_c  = 1'b1;
      id_stall_c  = 1'b1;
      ex_stall_c  = 1'b1;
      mem_stall_c = 1'b1;
    end else if (hz.ex_mispredict) begin
      id_flush_c  = 1'b1;
      ex_flush_c  = 1'b1;
    end else if (release_c) begin
      // The ready cycle releases every stage; nothing else may hold it.
      if_stall_c  = 1'b0;
    end else if (load_use) begin
      if_stall_c  = 1'b1;
      id_stall_c  = 1'b1;
      ex_flush_c  = 1'b1;
    end else if (!hz.imem_ready) begin
      if_stall_c  = 1'b1;
      id_flush_c  = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (if_stall_c && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.if_stall     = if_stall_c;
  assign hz.id_stall     = id_stall_c;
  assign hz.ex_stall     = ex_stall_c;
  assign hz.mem_stall    = mem_stall_c;
  assign hz.id_flush     = id_flush_c;
  assign hz.ex_flush     = ex_flush_c;
  assign hz.halted       = (state_q == HALT);
  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle vectors plus
// hand-written sequences for memory wait, timeout/halt, reset and counter
// saturation.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hz ();
  hazard_ctrl_if #(.CNT_W(4))  hzb ();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  hazard_ctrl #(.TIMEOUT(64), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .hz  (hzb)
  );

  // ctl ordering: {if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush}
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       mp;
    logic       imr;
    logic       dreq;
    logic       drdy;
    logic [5:0] ctl;
    logic       halt;
  } vec_t;

  typedef struct packed {
    logic [5:0] ctl;
    logic       halt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;
  vec_t        tbl[12];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2,
                              input logic [4:0] rd, input logic mr,
                              input logic mp, input logic imr,
                              input logic dreq, input logic drdy,
                              input logic [5:0] ctl, input logic halt);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.mr = mr;
    v.mp = mp; v.imr = imr; v.dreq = dreq; v.drdy = drdy; v.ctl = ctl;
    v.halt = halt;
    return v;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {hz.if_stall, hz.id_stall, hz.ex_stall, hz.mem_stall,
            hz.id_flush, hz.ex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.id_rs1        = v.rs1;
    hz.id_rs2        = v.rs2;
    hz.id_rs1_used   = v.u1;
    hz.id_rs2_used   = v.u2;
    hz.ex_rd         = v.rd;
    hz.ex_mem_read   = v.mr;
    hz.ex_mispredict = v.mp;
    hz.imem_ready    = v.imr;
    hz.dmem_req      = v.dreq;
    hz.dmem_ready    = v.drdy;
  endtask

  // One cycle: drive just after posedge, push expectation, compare at negedge.
  task automatic step(input string name, input vec_t v);
    exp_t e;
    drive(v);
    e.ctl  = v.ctl;
    e.halt = v.halt;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk({name, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".ctl"}, 32'(ctl_now()), 32'(e.ctl));
      chk({name, ".halted"}, 32'(hz.halted), 32'(e.halt));
      chk({name, ".cnt"}, hz.stall_cycles, exp_cnt);
    end
    @(posedge clk);
    #1;
    if (e.ctl[5] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
  endtask

  vec_t nrm, lu, w, wmp, rdy, mpv, hlt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                  rs1  rs2  u1 u2 rd  mr mp imr dq dr ctl         halt
    nrm = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 6'b000000, 0);
    lu  = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 0, 0, 6'b110001, 0);
    w   = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 6'b111100, 0);
    wmp = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, 0, 6'b111100, 0);
    rdy = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, 6'b000000, 0);
    mpv = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 0, 6'b000011, 0);
    hlt = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 6'b111100, 1);

    tbl[0]  = nrm;
    tbl[1]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 0, 0, 6'b110001, 0);
    tbl[2]  = mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 1, 0, 0, 6'b000000, 0);
    tbl[3]  = mk(5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 1, 0, 0, 6'b110001, 0);
    tbl[4]  = mk(5'd7, 5'd0, 0, 0, 5'd7, 1, 0, 1, 0, 0, 6'b000000, 0);
    tbl[5]  = mk(5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 1, 0, 0, 6'b000000, 0);
    tbl[6]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 6'b100010, 0);
    tbl[7]  = mk(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0, 0, 6'b110001, 0);
    tbl[8]  = mk(5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, 0, 6'b000011, 0);
    tbl[9]  = mpv;
    tbl[10] = mk(5'd2, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, 6'b000000, 0);
    tbl[11] = mk(5'd4, 5'd6, 1, 0, 5'd6, 1, 0, 1, 0, 0, 6'b000000, 0);

    // Reset state
    rst = 1'b0;
    exp_cnt = 32'd0;
    drive(nrm);
    hzb.id_rs1 = 5'd0; hzb.id_rs2 = 5'd0; hzb.id_rs1_used = 1'b0;
    hzb.id_rs2_used = 1'b0; hzb.ex_rd = 5'd0; hzb.ex_mem_read = 1'b0;
    hzb.ex_mispredict = 1'b0; hzb.imem_ready = 1'b1; hzb.dmem_req = 1'b0;
    hzb.dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctl", 32'(ctl_now()), 32'd0);
    chk("reset.halted", 32'(hz.halted), 32'd0);
    chk("reset.cnt", hz.stall_cycles, 32'd0);
    rst = 1'b1;

    // Single load-use occurrence stalls exactly one cycle
    step("lu_once", lu);
    step("lu_after", nrm);
    chk("lu_once.cnt_total", hz.stall_cycles, 32'd1);

    // Combinational vector table
    for (int i = 0; i < 12; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Memory wait of three cycles, mispredict ignored during the freeze
    step("dw0", w);
    step("dw1", wmp);
    step("dw2", wmp);
    step("dw_ready", rdy);
    step("dw_mp_again", mpv);

    // Timeout: RUN freeze cycle plus four DMEM_WAIT cycles, then HALT
    for (int i = 0; i < 5; i++) step($sformatf("to_wait%0d", i), w);
    for (int i = 0; i < 3; i++) step($sformatf("halt%0d", i), hlt);

    // Asynchronous reset out of HALT; outputs follow RUN rules meanwhile
    drive(lu);
    #2;
    rst = 1'b0;
    #1;
    exp_cnt = 32'd0;
    chk("halt_rst.halted", 32'(hz.halted), 32'd0);
    chk("halt_rst.cnt", hz.stall_cycles, 32'd0);
    chk("halt_rst.ctl", 32'(ctl_now()), 32'b110001);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_halt0", nrm);
    step("post_halt1", rdy);

    // Reset in the middle of a memory wait leaves no residual stall
    step("mw0", w);
    step("mw1", w);
    drive(nrm);
    #2;
    rst = 1'b0;
    #1;
    exp_cnt = 32'd0;
    chk("mw_rst.ctl", 32'(ctl_now()), 32'd0);
    chk("mw_rst.cnt", hz.stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_mw", nrm);

    // Narrow counter saturates at 15 without wrapping
    hzb.imem_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("sat.if_stall", 32'(hzb.if_stall), 32'd1);
    chk("sat.cnt10", 32'(hzb.stall_cycles), 32'd10);
    repeat (10) @(posedge clk);
    #1;
    chk("sat.cnt20", 32'(hzb.stall_cycles), 32'd15);
    repeat (5) @(posedge clk);
    #1;
    hzb.imem_ready = 1'b1;
    chk("sat.cnt25", 32'(hzb.stall_cycles), 32'd15);
    repeat (2) @(posedge clk);
    #1;
    chk("sat.hold", 32'(hzb.stall_cycles), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
